lcd_num_writer: RTL

Producer for the 16x2 character-LCD display buffer. It accepts an unsigned binary value and converts it to decimal ASCII with a sequential double-dabble. It then writes the digits, one character per cycle, into the buffer's write port (data/enable/pos/row) at a chosen row and start column. The loopback and status demos use it to print counters and rates on the board LCD without software.

---
 rtl/lcd_num_writer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_num_writer.sv
// lcd_num_writer: binary to decimal ASCII writer for the 16x2 LCD buffer.
// Sequential double-dabble, then one character per cycle, MSD first.
module lcd_num_writer #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             row,
  input  logic [3:0]       pos,
  input  logic             blank_zeros,
  output logic             busy,
  output logic             done,
  output logic [7:0]       lcd_data,
  output logic             lcd_enable,
  output logic [3:0]       lcd_pos,
  output logic             lcd_row
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            row_q, row_d;
  logic [3:0]      pos_q, pos_d;
  logic            blank_q, blank_d;
  logic            nz_q, nz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      data_q, data_d;
  logic            en_q, en_d;
  logic [3:0]      lpos_q, lpos_d;
  logic            lrow_q, lrow_d;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   step_bcd;
  logic [BW-1:0]   cur_bcd;
  logic [IW-1:0]   cur_idx;
  logic [3:0]      digit;
  logic            last;
  logic            space;
  logic [7:0]      chr;

  // Add-3 correction on every nibble, then the shifted BCD for this step.
  always_comb begin
    adj = bcd_q;
    for (int n = 0; n < DIGITS; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
    end
    step_bcd = {adj[BW-2:0], shift_q[WIDTH-1]};
  end

  // Character currently being emitted: top nibble, with zero blanking.
  always_comb begin
    cur_bcd = (state_q == S_CONV) ? step_bcd : bcd_q;
    cur_idx = (state_q == S_CONV) ? '0 : idx_q;
    digit   = cur_bcd[BW-1 -: 4];
    last    = (cur_idx == IW'(DIGITS - 1));
    space   = blank_q && (digit == 4'd0) && !nz_q && !last;
    chr     = space ? 8'h20 : {4'h3, digit};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    row_d   = row_q;
    pos_d   = pos_q;
    blank_d = blank_q;
    nz_d    = nz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    en_d    = 1'b0;
    lpos_d  = lpos_q;
    lrow_d  = lrow_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d = value;
          row_d   = row;
          pos_d   = pos;
          blank_d = blank_zeros;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          nz_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        shift_d = shift_q << 1;
        if (cnt_q == '0) begin
          bcd_d   = cur_bcd << 4;
          idx_d   = IW'(1);
          en_d    = 1'b1;
          data_d  = chr;
          lpos_d  = pos_q + cur_idx[3:0];
          lrow_d  = row_q;
          nz_d    = nz_q | (digit != 4'd0);
          state_d = S_WRITE;
        end else begin
          bcd_d = step_bcd;
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WRITE: begin
        if (idx_q == IW'(DIGITS)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          bcd_d  = cur_bcd << 4;
          idx_d  = idx_q + 1'b1;
          en_d   = 1'b1;
          data_d = chr;
          lpos_d = pos_q + cur_idx[3:0];
          lrow_d = row_q;
          nz_d   = nz_q | (digit != 4'd0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      row_q   <= 1'b0;
      pos_q   <= '0;
      blank_q <= 1'b0;
      nz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      lpos_q  <= '0;
      lrow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      pos_q   <= pos_d;
      blank_q <= blank_d;
      nz_q    <= nz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      en_q    <= en_d;
      lpos_q  <= lpos_d;
      lrow_q  <= lrow_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign lcd_data   = data_q;
  assign lcd_enable = en_q;
  assign lcd_pos    = lpos_q;
  assign lcd_row    = lrow_q;

endmodule
